// File: rtl/heater_pkg.sv
`default_nettype none
// ============================================================================
// Module   : heater_pkg
// Purpose  : shared types and sizing helpers for heater control blocks
// Revision : 1.0
// ============================================================================
package heater_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_UP   = 3'd1,
    ST_HOLD = 3'd2,
    ST_DOWN = 3'd3,
    ST_TRIP = 3'd4
  } heater_seq_state_t;

  localparam int FAULT_CNT_W = 8;

  // Bits needed to hold a heater count in 0..n.
  function automatic int lvl_width(input int n);
    return $clog2(n + 1);
  endfunction

  // Bits needed to hold a down-counter reload value of n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/heater_step_timer.sv
`default_nettype none
// ============================================================================
// Module   : heater_step_timer
// Purpose  : loadable down-counter; tc is high while enabled and at zero
// Revision : 1.0
// ============================================================================
module heater_step_timer #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             tc
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = en && (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/heater_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : heater_sequencer
// Purpose  : one-step-at-a-time heater soft start with fault masking and trip.
//            Define HEATER_SEQ_AUTOCLR_EN for timed auto-retry of faulted heaters.
// Revision : 1.0
// ============================================================================
module heater_sequencer
  import heater_pkg::*;
#(
  parameter int  N            = 32,
  parameter int  STEP_CYCLES  = 1024,
  parameter int  MAX_FAULTS   = 8,
  parameter int  RETRY_CYCLES = 65536,
  localparam int LW           = lvl_width(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  input  logic [LW-1:0] target,
  input  logic          fault_clear,
  input  logic [N-1:0]  heater_error,
  output logic [N-1:0]  heater_enable,
  output logic [N-1:0]  heater_err_clear,
  output logic [LW-1:0] level,
  output logic [N-1:0]  faulted,
  output logic          tripped,
  output logic          busy
);

  localparam int                     STEP_W    = cnt_width(STEP_CYCLES);
  localparam logic [STEP_W-1:0]      STEP_LOAD = STEP_W'(STEP_CYCLES - 1);
  localparam logic [LW-1:0]          LVL_MAX   = LW'(N);
  localparam logic [FAULT_CNT_W-1:0] TRIP_CNT  = FAULT_CNT_W'(MAX_FAULTS);
  localparam logic [FAULT_CNT_W-1:0] CNT_SAT   = '1;

  heater_seq_state_t      state_q, state_d;
  logic [LW-1:0]          level_q, level_d;
  logic [LW-1:0]          goal;
  logic [N-1:0]           err_q;
  logic [N-1:0]           enable_q, enable_d;
  logic [N-1:0]           err_clear_q, err_clear_d;
  logic [N-1:0]           faulted_q, faulted_d;
  logic [N-1:0]           fresh_q, fresh_d;
  logic [N-1:0]           new_fault;
  logic [N-1:0]           thermo;
  logic [FAULT_CNT_W-1:0] fault_cnt_q, fault_cnt_d;
  logic                   busy_q, busy_d;
  logic                   tripped_q, tripped_d;
  logic                   step_load, step_en, step_tc;
  logic                   retry_tc;

  assign goal = !run ? '0 : ((target > LVL_MAX) ? LVL_MAX : target);

  // ---------------------------------------------------------------- sequencer
  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    step_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (goal != '0) begin
          state_d   = ST_UP;
          step_load = 1'b1;
        end
      end
      ST_HOLD: begin
        if (goal > level_q) begin
          state_d   = ST_UP;
          step_load = 1'b1;
        end else if (goal < level_q) begin
          state_d   = ST_DOWN;
          step_load = 1'b1;
        end
      end
      ST_UP, ST_DOWN: begin
        // Direction is re-derived from the live goal at every step, so a
        // mid-ramp goal change can reverse the ramp without a HOLD stop.
        if (goal == level_q) begin
          state_d = (level_q == '0) ? ST_IDLE : ST_HOLD;
        end else if (step_tc) begin
          level_d   = (goal > level_q) ? level_q + LW'(1) : level_q - LW'(1);
          step_load = 1'b1;
          if (level_d == goal) begin
            state_d = (level_d == '0) ? ST_IDLE : ST_HOLD;
          end else begin
            state_d = (goal > level_d) ? ST_UP : ST_DOWN;
          end
        end
      end
      ST_TRIP: begin
        level_d = '0;
        if (fault_clear && !run) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        level_d = '0;
      end
    endcase

    if ((state_q != ST_TRIP) && (fault_cnt_q == TRIP_CNT)) begin
      state_d   = ST_TRIP;
      level_d   = '0;
      step_load = 1'b0;
    end
  end

  assign step_en = (state_q == ST_UP) || (state_q == ST_DOWN);

  heater_step_timer #(
    .WIDTH (STEP_W)
  ) u_step_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (step_load),
    .load_val (STEP_LOAD),
    .en       (step_en),
    .tc       (step_tc)
  );

  // ------------------------------------------------------------ fault handling
  always_comb begin
    new_fault   = err_q & enable_q & ~faulted_q;
    faulted_d   = faulted_q;
    fault_cnt_d = fault_cnt_q;
    fresh_d     = '0;
    if (fault_clear) begin
      faulted_d   = '0;
      fault_cnt_d = '0;
    end else begin
      faulted_d = (retry_tc ? '0 : faulted_q) | new_fault;
      fresh_d   = new_fault;
      if ((new_fault != '0) && (fault_cnt_q != CNT_SAT)) begin
        fault_cnt_d = fault_cnt_q + FAULT_CNT_W'(1);
      end
    end
    err_clear_d = fresh_q | ((fault_clear || retry_tc) ? faulted_q : '0);
  end

  // Enables use the next fault mask and state so a fault or trip drops the
  // affected enables on the same edge that records it.
  always_comb begin
    thermo = '0;
    for (int i = 0; i < N; i++) begin
      thermo[i] = (LW'(i) < level_q);
    end
    enable_d  = (state_d == ST_TRIP) ? '0 : (thermo & ~faulted_d);
    busy_d    = (state_d == ST_UP) || (state_d == ST_DOWN);
    tripped_d = (state_d == ST_TRIP);
  end

`ifdef HEATER_SEQ_AUTOCLR_EN
  localparam int                 RETRY_W    = cnt_width(RETRY_CYCLES);
  localparam logic [RETRY_W-1:0] RETRY_LOAD = RETRY_W'(RETRY_CYCLES - 1);

  logic retry_load;
  logic retry_en;

  assign retry_load = (faulted_q == '0) && (faulted_d != '0);
  assign retry_en   = (faulted_q != '0) && (state_q != ST_TRIP);

  heater_step_timer #(
    .WIDTH (RETRY_W)
  ) u_retry_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (retry_load),
    .load_val (RETRY_LOAD),
    .en       (retry_en),
    .tc       (retry_tc)
  );
`else
  logic unused_retry_cfg;
  assign unused_retry_cfg = (RETRY_CYCLES != 0);
  assign retry_tc         = 1'b0;
`endif

  // ----------------------------------------------------------------- registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      level_q     <= '0;
      err_q       <= '0;
      enable_q    <= '0;
      err_clear_q <= '0;
      faulted_q   <= '0;
      fresh_q     <= '0;
      fault_cnt_q <= '0;
      busy_q      <= 1'b0;
      tripped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      err_q       <= heater_error;
      enable_q    <= enable_d;
      err_clear_q <= err_clear_d;
      faulted_q   <= faulted_d;
      fresh_q     <= fresh_d;
      fault_cnt_q <= fault_cnt_d;
      busy_q      <= busy_d;
      tripped_q   <= tripped_d;
    end
  end

  assign heater_enable    = enable_q;
  assign heater_err_clear = err_clear_q;
  assign level            = level_q;
  assign faulted          = faulted_q;
  assign tripped          = tripped_q;
  assign busy             = busy_q;

endmodule
`default_nettype wire

// File: doc/heater_sequencer.md
# heater_sequencer

Soft-start controller for the heater array in the power-stress design. Runs on the fast heater clock and sequences the per-heater `enable` bits one heater at a time toward a requested count, which bounds supply di/dt. It also latches per-heater errors, masks faulted heaters, issues `err_clear` pulses, and trips the whole array off when too many faults accumulate. Sits between the VIO control registers (after their pipeline flops) and the heater instances, replacing direct VIO drive of `heater_enable` and `heater_err_clear`.

## Interface
- `N`, 32, number of heaters controlled.
- `STEP_CYCLES`, 1024, clk cycles between successive level changes (≥1).
- `MAX_FAULTS`, 8, accumulated fault detections that cause a trip (1..255).
- `RETRY_CYCLES`, 65536, auto-clear retry delay (used only with the macro).

Ports:
- `clk` in 1: heater clock; sole clock.
- `reset` in 1: synchronous, active-high.
- `run` in 1: level request; 0 means goal = 0.
- `target` in LW=$clog2(N+1): requested heater count; values > N clamp to N.
- `fault_clear` in 1: single-cycle request to clear faults and trip state.
- `heater_error` in N: per-heater error from heaters; asynchronous source, registered once internally.
- `heater_enable` out N: per-heater enable.
- `heater_err_clear` out N: per-heater error-clear pulse.
- `level` out LW: heaters currently sequenced on (before fault masking).
- `faulted` out N: latched fault mask.
- `tripped` out 1: array tripped.
- `busy` out 1: ramp in progress.

## Operation
- Goal: `run ? min(target, N) : 0`, evaluated every cycle.
- `heater_enable[i] = (i < level) & ~faulted[i] & ~tripped`. The output is registered.
- States:
  - IDLE: level = 0.
  - UP.
  - HOLD: level = goal, nonzero.
  - DOWN.
  - TRIP.
- Transitions:
  - IDLE→UP when goal > 0.
  - HOLD→UP when goal > level; HOLD→DOWN when goal < level.
  - UP/DOWN→HOLD when level reaches a nonzero goal; DOWN→IDLE when level reaches 0.
  - A goal change mid-ramp re-evaluates the direction at the next step. Reversal is allowed without passing through HOLD.
- Step timer: reloads to STEP_CYCLES−1 on entry to UP/DOWN and after each step. Level changes by exactly ±1 when the timer hits 0. The first step occurs STEP_CYCLES cycles after the goal change is registered.
- Fault detect: `err_q = heater_error` registered. If `err_q[i] & heater_enable[i] & ~faulted[i]`:
  - `faulted[i]` is set;
  - `fault_cnt` (8-bit, saturating) increments by 1 per cycle with any new fault, regardless of how many bits are new;
  - every newly faulted heater gets one err_clear pulse the following cycle.
- Trip: `fault_cnt == MAX_FAULTS` → TRIP. In TRIP, all enables are 0 and level is forced to 0.
- `fault_clear`:
  - pulses `heater_err_clear` = faulted mask for 1 cycle;
  - clears faulted and fault_cnt;
  - from TRIP, goes to IDLE only if `run == 0`; otherwise TRIP is kept with faults cleared.
- `fault_clear` wins over a same-cycle new fault. The new fault is re-detected next cycle if the error persists.
- `reset` mid-ramp: all state returns to reset values immediately. Enables drop on the next edge.

## Timing
- Reset values: heater_enable = 0, heater_err_clear = 0, level = 0, faulted = 0, tripped = 0, busy = 0; state IDLE; fault_cnt = 0.
- Error latency: heater_error → faulted set is 2 cycles. heater_enable drops in the same cycle that faulted is set. heater_err_clear pulses 1 cycle after that.
- Level step → heater_enable change: 1 cycle.
- `busy` = state ∈ {UP, DOWN}; `tripped` = state == TRIP. Both are registered.

## Configuration
- `HEATER_SEQ_AUTOCLR_EN` defined:
  - a shared retry timer starts at RETRY_CYCLES−1 when faulted first goes nonzero;
  - on expiry: 1-cycle err_clear to all faulted heaters, faulted cleared; fault_cnt is NOT cleared, so repeat offenders still trip;
  - the timer is suspended in TRIP.
- Undefined: faulted heaters stay masked until `fault_clear`. RETRY_CYCLES is ignored.

## Structure
- Package `heater_pkg`: state enum type `heater_seq_state_t`, the LW width function/localparam, and fault-counter width. Shared with any future heater control blocks.
- One sub-module: `heater_step_timer` (loadable down-counter with terminal-count pulse), also reused for the retry timer.

## Test plan
- N=32, STEP_CYCLES=4, run=1, target=5 → level 1..5 at cycles 4, 8, 12, 16, 20 after run; heater_enable = 0x1F; busy deasserts at the HOLD entry.
- In HOLD at 5, target=40 → clamps and ramps to 32; heater_enable = 0xFFFFFFFF; then run=0 → ramps down to 0, IDLE.
- Level 5, heater_error[2] held 1 → 2 cycles later faulted = 0x4, heater_enable = 0x1B; heater_err_clear = 0x4 for exactly 1 cycle.
- MAX_FAULTS=2, errors on heaters 0 and 1 in separate cycles → tripped = 1, heater_enable = 0. fault_clear with run=1 keeps TRIP; with run=0 → IDLE.
- Ramp up to 8, then target=3 at level 6 → reverses and settles at 3 with no overshoot past 6.
- `HEATER_SEQ_AUTOCLR_EN`, RETRY_CYCLES=16, one error pulse on heater 3 → faulted = 0x8, then after 16 cycles err_clear = 0x8 and heater 3 re-enabled; fault_cnt = 1.
